seq_alu: RTL and testbench

- Multi-cycle arithmetic/logic unit directly downstream of the processor control unit.
- Accepts a start request (bgn) with a 6-bit opcode and two 16-bit operands, and executes the operation.
- Returns a primary result (acc1), a secondary result (acc2) and the four status flags, then pulses rdy for one cycle.
- Single-cycle operations finish in 1 cycle; MUL/DIV/MOD are iterative (16 steps).

---
 rtl/seq_alu.sv | 376 +++++++++++++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- multi-cycle arithmetic/logic unit behind the processor control unit.
//
// A start request (bgn) sampled in IDLE latches the function code opcode[5:1]
// and both operands. Single-cycle functions finish through EXEC. MUL runs a
// shift-add loop and DIV/MOD run a restoring-division loop, one bit per cycle.
// Results and flags are registered and held until the next completion. rdy
// pulses for the one cycle spent in DONE.
//
// Ports:
//   clk       in   system clock, all state on the rising edge
//   rst       in   synchronous active-low reset
//   bgn       in   start request, only looked at in IDLE
//   opcode    in   [5:1] function code, [0] ignored
//   A, B      in   operands (WIDTH bits)
//   acc1      out  primary result
//   acc2      out  secondary result (MUL high word, DIV remainder, MOD quotient)
//   zero      out  result-is-zero flag
//   negative  out  result sign flag
//   carry     out  carry / borrow / last shifted-out bit
//   overflow  out  signed overflow (also set on divide by zero)
//   rdy       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bgn,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] acc1,
    output logic [WIDTH-1:0] acc2,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             rdy
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER);
    localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] SH_ONE   = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0] SH_ZERO  = {SW{1'b0}};

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_LSR = 5'b00011;
    localparam logic [4:0] OP_LSL = 5'b00100;
    localparam logic [4:0] OP_RSR = 5'b00101;
    localparam logic [4:0] OP_RSL = 5'b00110;
    localparam logic [4:0] OP_MUL = 5'b00111;
    localparam logic [4:0] OP_DIV = 5'b01000;
    localparam logic [4:0] OP_MOD = 5'b01001;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_XOR = 5'b01100;
    localparam logic [4:0] OP_NOT = 5'b01101;
    localparam logic [4:0] OP_CMP = 5'b01110;
    localparam logic [4:0] OP_TST = 5'b01111;
    localparam logic [4:0] OP_INC = 5'b10000;
    localparam logic [4:0] OP_DEC = 5'b10001;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MULT = 3'd2,
        S_DIVD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;

    logic [WIDTH-1:0]   r_acc1;
    logic [WIDTH-1:0]   r_acc2;
    logic               r_zero;
    logic               r_neg;
    logic               r_carry;
    logic               r_ovf;
    logic               r_rdy;

    logic [4:0]         w_func_in;
    logic               w_unused_opc0;
    logic               w_last;
    logic               w_div0;

    // single-cycle datapath
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sub_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic               w_add_v;
    logic               w_sub_v;
    logic [SW-1:0]      w_sh;
    logic [SW-1:0]      w_sh_m1;
    logic [SW-1:0]      w_sh_inv;
    logic               w_sh_nz;

    logic [WIDTH-1:0]   w_ex_acc1;
    logic               w_ex_c;
    logic               w_ex_v;
    logic               w_ex_we;
    logic               w_ex_zn_alt;
    logic [WIDTH-1:0]   w_ex_zn_val;
    logic               w_ex_z;
    logic               w_ex_n;

    // iterative datapath
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_div_res1;
    logic [WIDTH-1:0]   w_div_res2;

    assign w_func_in     = opcode[5:1];
    assign w_unused_opc0 = opcode[0];
    assign w_last        = (r_cnt == CNT_LAST);
    // Count 0 is the load step, so a zero divisor is known from count 1 on.
    assign w_div0        = (r_cnt != CNT_ZERO) && (r_b == W_ZERO);

    // INC/DEC reuse the adder/subtractor with a constant one as second operand.
    assign w_add_b  = (r_op == OP_INC) ? W_ONE : r_b;
    assign w_sub_b  = (r_op == OP_DEC) ? W_ONE : r_b;
    assign w_add    = {1'b0, r_a} + {1'b0, w_add_b};
    assign w_sub    = {1'b0, r_a} - {1'b0, w_sub_b};
    assign w_add_v  = (r_a[WIDTH-1] == w_add_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
    assign w_sub_v  = (r_a[WIDTH-1] != w_sub_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);

    // w_sh_inv is WIDTH-s modulo WIDTH: the complementary rotate distance and
    // the index of the last bit pushed out by a left shift.
    assign w_sh     = r_b[SW-1:0];
    assign w_sh_m1  = w_sh - SH_ONE;
    assign w_sh_inv = SH_ZERO - w_sh;
    assign w_sh_nz  = (w_sh != SH_ZERO);

    // Shift-add step: r_prod holds {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_prod_nxt = r_prod[0] ? {w_mul_sum, r_prod[WIDTH-1:1]}
                                  : {1'b0, r_prod[2*WIDTH-1:1]};

    // Restoring-division step: a set bit WIDTH of the trial difference means
    // the divisor did not fit, so the shifted remainder is kept.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
    assign w_rem_nxt   = w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[WIDTH-2:0], ~w_div_diff[WIDTH]};
    assign w_div_res1  = (r_op == OP_MOD) ? w_rem_nxt : w_quo_nxt;
    assign w_div_res2  = (r_op == OP_MOD) ? w_quo_nxt : w_rem_nxt;

    assign acc1     = r_acc1;
    assign acc2     = r_acc2;
    assign zero     = r_zero;
    assign negative = r_neg;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign rdy      = r_rdy;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bgn) begin
                    if (w_func_in == OP_MUL) begin
                        w_state_nxt = S_MULT;
                    end else if ((w_func_in == OP_DIV) || (w_func_in == OP_MOD)) begin
                        w_state_nxt = S_DIVD;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: w_state_nxt = S_DONE;
            S_MULT: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_MULT;
                end
            end
            S_DIVD: begin
                if (w_last || w_div0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DIVD;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle function results and flags.
    always_comb begin
        w_ex_acc1   = r_a;
        w_ex_c      = 1'b0;
        w_ex_v      = 1'b0;
        w_ex_we     = 1'b1;
        w_ex_zn_alt = 1'b0;
        w_ex_zn_val = r_a;
        case (r_op)
            OP_ADD, OP_INC: begin
                w_ex_acc1 = w_add[WIDTH-1:0];
                w_ex_c    = w_add[WIDTH];
                w_ex_v    = w_add_v;
            end
            OP_SUB, OP_DEC: begin
                w_ex_acc1 = w_sub[WIDTH-1:0];
                w_ex_c    = w_sub[WIDTH];
                w_ex_v    = w_sub_v;
            end
            OP_CMP: begin
                // acc1 keeps A; only the flags see the difference.
                w_ex_acc1   = r_a;
                w_ex_c      = w_sub[WIDTH];
                w_ex_v      = w_sub_v;
                w_ex_zn_alt = 1'b1;
                w_ex_zn_val = w_sub[WIDTH-1:0];
            end
            OP_LSR: begin
                w_ex_acc1 = r_a >> w_sh;
                w_ex_c    = w_sh_nz & r_a[w_sh_m1];
            end
            OP_LSL: begin
                w_ex_acc1 = r_a << w_sh;
                w_ex_c    = w_sh_nz & r_a[w_sh_inv];
            end
            OP_RSR: begin
                w_ex_acc1 = (r_a >> w_sh) | (r_a << w_sh_inv);
                w_ex_c    = w_sh_nz & r_a[w_sh_m1];
            end
            OP_RSL: begin
                w_ex_acc1 = (r_a << w_sh) | (r_a >> w_sh_inv);
                w_ex_c    = w_sh_nz & r_a[w_sh_inv];
            end
            OP_AND: w_ex_acc1 = r_a & r_b;
            OP_OR:  w_ex_acc1 = r_a | r_b;
            OP_XOR: w_ex_acc1 = r_a ^ r_b;
            OP_NOT: w_ex_acc1 = ~r_a;
            OP_TST: begin
                w_ex_acc1   = r_a;
                w_ex_zn_alt = 1'b1;
                w_ex_zn_val = r_a & r_b;
            end
            default: begin
                // LDR/NOP/HLT and unused codes pass A and leave flags alone.
                w_ex_acc1 = r_a;
                w_ex_we   = 1'b0;
            end
        endcase
        if (w_ex_zn_alt) begin
            w_ex_z = (w_ex_zn_val == W_ZERO);
            w_ex_n = w_ex_zn_val[WIDTH-1];
        end else begin
            w_ex_z = (w_ex_acc1 == W_ZERO);
            w_ex_n = w_ex_acc1[WIDTH-1];
        end
    end

    // Operand latch, iteration registers, results, flags and rdy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op    <= 5'b00000;
            r_a     <= W_ZERO;
            r_b     <= W_ZERO;
            r_cnt   <= CNT_ZERO;
            r_prod  <= {(2*WIDTH){1'b0}};
            r_rem   <= W_ZERO;
            r_quo   <= W_ZERO;
            r_acc1  <= W_ZERO;
            r_acc2  <= W_ZERO;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_rdy   <= 1'b0;
        end else begin
            r_rdy <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (bgn) begin
                        r_op  <= w_func_in;
                        r_a   <= A;
                        r_b   <= B;
                        r_cnt <= CNT_ZERO;
                    end
                end
                S_EXEC: begin
                    r_acc1 <= w_ex_acc1;
                    r_acc2 <= W_ZERO;
                    if (w_ex_we) begin
                        r_zero  <= w_ex_z;
                        r_neg   <= w_ex_n;
                        r_carry <= w_ex_c;
                        r_ovf   <= w_ex_v;
                    end
                end
                S_MULT: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_ZERO) begin
                        r_prod <= {W_ZERO, r_b};
                    end else begin
                        r_prod <= w_prod_nxt;
                        if (w_last) begin
                            r_acc1  <= w_prod_nxt[WIDTH-1:0];
                            r_acc2  <= w_prod_nxt[2*WIDTH-1:WIDTH];
                            r_zero  <= (w_prod_nxt[WIDTH-1:0] == W_ZERO);
                            r_neg   <= w_prod_nxt[WIDTH-1];
                            r_carry <= (w_prod_nxt[2*WIDTH-1:WIDTH] != W_ZERO);
                            r_ovf   <= (w_prod_nxt[2*WIDTH-1:WIDTH] != W_ZERO);
                        end
                    end
                end
                S_DIVD: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_ZERO) begin
                        r_rem <= W_ZERO;
                        r_quo <= r_a;
                    end else if (w_div0) begin
                        r_acc1  <= {WIDTH{1'b1}};
                        r_acc2  <= r_a;
                        r_zero  <= 1'b0;
                        r_neg   <= 1'b1;
                        r_carry <= 1'b0;
                        r_ovf   <= 1'b1;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (w_last) begin
                            r_acc1  <= w_div_res1;
                            r_acc2  <= w_div_res2;
                            r_zero  <= (w_div_res1 == W_ZERO);
                            r_neg   <= w_div_res1[WIDTH-1];
                            r_carry <= 1'b0;
                            r_ovf   <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_cnt <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu. A reference model computes
// each function from plain integer arithmetic; directed cases are followed by
// randomized operations, some with operand/bgn noise while the unit is busy.
// -----------------------------------------------------------------------------
module tb_seq_alu;

    localparam logic [4:0] F_NOP = 5'd0,  F_ADD = 5'd1,  F_SUB = 5'd2,  F_LSR = 5'd3;
    localparam logic [4:0] F_LSL = 5'd4,  F_RSR = 5'd5,  F_RSL = 5'd6,  F_MUL = 5'd7;
    localparam logic [4:0] F_DIV = 5'd8,  F_MOD = 5'd9,  F_AND = 5'd10, F_OR  = 5'd11;
    localparam logic [4:0] F_XOR = 5'd12, F_NOT = 5'd13, F_CMP = 5'd14, F_TST = 5'd15;
    localparam logic [4:0] F_INC = 5'd16, F_DEC = 5'd17;

    logic        clk = 1'b0;
    logic        rst;
    logic        bgn;
    logic [5:0]  opcode;
    logic [15:0] A, B;
    logic [15:0] acc1, acc2;
    logic        zero, negative, carry, overflow, rdy;

    int n_checks = 0;
    int n_errors = 0;

    // model's view of the flags {zero, negative, carry, overflow} and which are defined
    logic [3:0] m_flags;
    logic [3:0] m_fknown;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(16), .ITER(16)) dut (
        .clk(clk), .rst(rst), .bgn(bgn), .opcode(opcode), .A(A), .B(B),
        .acc1(acc1), .acc2(acc2), .zero(zero), .negative(negative),
        .carry(carry), .overflow(overflow), .rdy(rdy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: expected acc1/acc2/flags, defined-flag mask and latency.
    task automatic model(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] e1, output logic [15:0] e2,
                         output logic [3:0] ef, output logic [3:0] ek, output int elat);
        int sa, sb, r, s;
        logic [15:0] ub, znv;
        logic [31:0] t;
        logic c, v, cv_ok, zn_alt, keep;
        ub = (f == F_INC || f == F_DEC) ? 16'd1 : b;
        sa = int'($signed(a));
        sb = int'($signed(ub));
        s  = int'(b[3:0]);
        e1 = a; e2 = 16'h0000; elat = 2;
        c = 1'b0; v = 1'b0; cv_ok = 1'b1; zn_alt = 1'b0; znv = 16'h0000; keep = 1'b0;
        case (f)
            F_ADD, F_INC: begin
                t = 32'(a) + 32'(ub); e1 = t[15:0]; c = t[16];
                r = sa + sb; v = (r > 32767) || (r < -32768);
            end
            F_SUB, F_DEC, F_CMP: begin
                t = 32'(a) - 32'(ub); e1 = t[15:0]; c = (a < ub);
                r = sa - sb; v = (r > 32767) || (r < -32768);
                if (f == F_CMP) begin e1 = a; zn_alt = 1'b1; znv = t[15:0]; end
            end
            F_LSR: begin t = {a, 16'h0000} >> s; e1 = t[31:16]; c = t[15]; end
            F_LSL: begin t = {16'h0000, a} << s; e1 = t[15:0]; c = t[16]; end
            F_RSR: begin t = {a, a} >> s; e1 = t[15:0];  c = (s != 0) && e1[15]; end
            F_RSL: begin t = {a, a} << s; e1 = t[31:16]; c = (s != 0) && e1[0]; end
            F_MUL: begin
                t = 32'(a) * 32'(b); e1 = t[15:0]; e2 = t[31:16];
                c = (e2 != 16'h0000); v = c; elat = 18;
            end
            F_DIV, F_MOD: begin
                if (b == 16'h0000) begin
                    e1 = 16'hFFFF; e2 = a; c = 1'b0; v = 1'b1; elat = 3;
                end else begin
                    e1 = (f == F_DIV) ? a / b : a % b;
                    e2 = (f == F_DIV) ? a % b : a / b;
                    cv_ok = 1'b0; elat = 18;
                end
            end
            F_AND: e1 = a & b;
            F_OR:  e1 = a | b;
            F_XOR: e1 = a ^ b;
            F_NOT: e1 = ~a;
            F_TST: begin e1 = a; zn_alt = 1'b1; znv = a & b; cv_ok = 1'b0; end
            default: keep = 1'b1;
        endcase
        if (!zn_alt) znv = e1;
        if (keep) begin
            ef = m_flags; ek = m_fknown;
        end else begin
            ef = {(znv == 16'h0000), znv[15], c, v};
            ek = {1'b1, 1'b1, cv_ok, cv_ok};
        end
    endtask

    // One operation: start, optional busy-time noise, then compare on rdy.
    task automatic run_op(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b, input bit junk);
        logic [15:0] e1, e2;
        logic [3:0]  ef, ek, gf;
        int elat, lat;
        @(negedge clk);
        bgn = 1'b1; opcode = {f, 1'($urandom)}; A = a; B = b;
        model(f, a, b, e1, e2, ef, ek, elat);
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy) begin lat = k; break; end
            if (junk) begin
                bgn = 1'($urandom); A = 16'($urandom); B = 16'($urandom); opcode = 6'($urandom);
            end else begin
                bgn = 1'b0;
            end
        end
        bgn = 1'b0;
        check_val($sformatf("latency f=%0d", f), 32'(lat), 32'(elat));
        check_val($sformatf("acc1 f=%0d a=%h b=%h", f, a, b), 32'(acc1), 32'(e1));
        check_val($sformatf("acc2 f=%0d a=%h b=%h", f, a, b), 32'(acc2), 32'(e2));
        gf = {zero, negative, carry, overflow};
        if (ek[3]) check_val($sformatf("zero f=%0d", f), 32'(gf[3]), 32'(ef[3]));
        if (ek[2]) check_val($sformatf("negative f=%0d", f), 32'(gf[2]), 32'(ef[2]));
        if (ek[1]) check_val($sformatf("carry f=%0d", f), 32'(gf[1]), 32'(ef[1]));
        if (ek[0]) check_val($sformatf("overflow f=%0d", f), 32'(gf[0]), 32'(ef[0]));
        @(negedge clk);
        check_val($sformatf("rdy_pulse f=%0d", f), 32'(rdy), 32'd0);
        m_flags  = ef;
        m_fknown = ek;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int seen;
        logic [4:0] f;
        logic [15:0] a, b;
        m_flags = 4'h0; m_fknown = 4'hF;
        rst = 1'b0; bgn = 1'b1; opcode = {F_ADD, 1'b0}; A = 16'd7; B = 16'd9;

        // reset held with bgn high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_acc", {acc1, acc2}, 32'h0);
        check_val("reset_flags_rdy", 32'({zero, negative, carry, overflow, rdy}), 32'h0);
        bgn = 1'b0; rst = 1'b1;

        // reset in the middle of a MUL aborts it without rdy
        @(negedge clk);
        bgn = 1'b1; opcode = {F_MUL, 1'b0}; A = 16'h1234; B = 16'h0100;
        @(posedge clk);
        @(negedge clk); bgn = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (rdy) seen++;
        end
        check_val("abort_rdy_count", 32'(seen), 32'd0);
        check_val("abort_acc", {acc1, acc2}, 32'h0);

        // directed cases
        run_op(F_ADD, 16'h7FFF, 16'h0001, 1'b0);
        run_op(F_SUB, 16'd3, 16'd5, 1'b0);
        run_op(F_CMP, 16'd5, 16'd5, 1'b0);
        run_op(F_MUL, 16'h1234, 16'h0100, 1'b1);
        run_op(F_DIV, 16'd100, 16'd7, 1'b0);
        run_op(F_MOD, 16'd100, 16'd7, 1'b1);
        run_op(F_DIV, 16'd9, 16'd0, 1'b0);
        run_op(F_LSL, 16'h8001, 16'd1, 1'b0);
        run_op(F_NOP, 16'h0000, 16'h1234, 1'b0);
        run_op(F_RSR, 16'h0001, 16'd4, 1'b0);
        run_op(F_LSR, 16'h8001, 16'h0010, 1'b0);
        run_op(5'd31, 16'h4321, 16'd0, 1'b1);
        run_op(F_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
        run_op(F_DEC, 16'h8000, 16'd0, 1'b0);
        run_op(F_INC, 16'hFFFF, 16'd0, 1'b0);

        // randomized operations
        for (int n = 0; n < 200; n++) begin
            f = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(1, 17));
            a = pick();
            b = pick();
            run_op(f, a, b, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
